control_sequencer: RTL

Multi-cycle control sequencer that consumes the 33-bit control words produced by the per-opcode decoders (BL, B, R-type, D-type, …) and drives the datapath.

- **Fetch phase:** owns the cycle, reads the instruction from RAM over the databus and latches it into the instruction register.
- **Execute phase:** feeds the instruction register and the micro-step `state` back to the decoders, passes their control word through to the datapath, and follows each word's `next_state` field.
- **Status and stalls:** also holds the architectural status flags and stalls on slow memory.

---
 rtl/cu_pkg.sv | 84 ++++++++
 rtl/cw_gate.sv | 36 +++
 rtl/control_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the control sequencer: control-word layout, PC
// function encodings, the fixed fetch control word and the phase encoding.
package cu_pkg;

    localparam int unsigned CW_WIDTH = 33;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned ALU_FS_W = 5;
    localparam int unsigned PC_FS_W  = 2;
    localparam int unsigned NS_W     = 2;
    localparam int unsigned STATUS_W = 5;
    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned K_W      = 64;

    localparam int unsigned ALU_EN_BIT     = 32;
    localparam int unsigned ALU_BS_BIT     = 31;
    localparam int unsigned ALU_FS_LSB     = 26;
    localparam int unsigned RF_B_EN_BIT    = 25;
    localparam int unsigned RF_SA_LSB      = 20;
    localparam int unsigned RF_SB_LSB      = 15;
    localparam int unsigned RF_DA_LSB      = 10;
    localparam int unsigned RF_W_BIT       = 9;
    localparam int unsigned RAM_EN_BIT     = 8;
    localparam int unsigned RAM_W_BIT      = 7;
    localparam int unsigned PC_EN_BIT      = 6;
    localparam int unsigned PC_FS_LSB      = 4;
    localparam int unsigned PC_IS_BIT      = 3;
    localparam int unsigned STATUS_LD_BIT  = 2;
    localparam int unsigned NEXT_STATE_LSB = 0;

    localparam logic [PC_FS_W-1:0] PC_FS_HOLD = 2'b00;
    localparam logic [PC_FS_W-1:0] PC_FS_INC  = 2'b01;
    localparam logic [PC_FS_W-1:0] PC_FS_LOAD = 2'b10;
    localparam logic [PC_FS_W-1:0] PC_FS_REL  = 2'b11;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } phase_e;

    // Assemble a control word from its individual fields.
    function automatic logic [CW_WIDTH-1:0] pack_cw(
        input logic                alu_en,
        input logic                alu_bs,
        input logic [ALU_FS_W-1:0] alu_fs,
        input logic                rf_b_en,
        input logic [REG_W-1:0]    rf_sa,
        input logic [REG_W-1:0]    rf_sb,
        input logic [REG_W-1:0]    rf_da,
        input logic                rf_w,
        input logic                ram_en,
        input logic                ram_w,
        input logic                pc_en,
        input logic [PC_FS_W-1:0]  pc_fs,
        input logic                pc_is,
        input logic                status_ld,
        input logic [NS_W-1:0]     next_state
    );
        logic [CW_WIDTH-1:0] w;
        w                            = '0;
        w[ALU_EN_BIT]                = alu_en;
        w[ALU_BS_BIT]                = alu_bs;
        w[ALU_FS_LSB +: ALU_FS_W]    = alu_fs;
        w[RF_B_EN_BIT]               = rf_b_en;
        w[RF_SA_LSB +: REG_W]        = rf_sa;
        w[RF_SB_LSB +: REG_W]        = rf_sb;
        w[RF_DA_LSB +: REG_W]        = rf_da;
        w[RF_W_BIT]                  = rf_w;
        w[RAM_EN_BIT]                = ram_en;
        w[RAM_W_BIT]                 = ram_w;
        w[PC_EN_BIT]                 = pc_en;
        w[PC_FS_LSB +: PC_FS_W]      = pc_fs;
        w[PC_IS_BIT]                 = pc_is;
        w[STATUS_LD_BIT]             = status_ld;
        w[NEXT_STATE_LSB +: NS_W]    = next_state;
        return w;
    endfunction

    // Instruction read: RAM enabled, ALU passes through, no writes, PC held.
    localparam logic [CW_WIDTH-1:0] FETCH_CW = pack_cw(
        1'b0, 1'b0, 5'b11111, 1'b0, 5'd31, 5'd31, 5'd0,
        1'b0, 1'b1, 1'b0, 1'b0, PC_FS_HOLD, 1'b0, 1'b0, 2'b00
    );

endpackage

// File: rtl/cw_gate.sv
// Combinational control-word selector: fetch word or decoder word, with
// memory-stall masking and a forced all-zero word while reset is held.
module cw_gate
    import cu_pkg::*;
(
    input  logic                reset_n_i,
    input  phase_e              phase_i,
    input  logic                mem_ready_i,
    input  logic [CW_WIDTH-1:0] cw_i,
    output logic [CW_WIDTH-1:0] cw_c_o,
    output logic                stall_c_o
);

    always_comb begin
        cw_c_o    = '0;
        stall_c_o = 1'b0;
        if (reset_n_i) begin
            if (phase_i == FETCH) begin
                cw_c_o = FETCH_CW;
                if (mem_ready_i) begin
                    cw_c_o[PC_FS_LSB +: PC_FS_W] = PC_FS_INC;
                end
            end else begin
                cw_c_o = cw_i;
                // A memory access without a ready RAM must not commit anything.
                if (cw_i[RAM_EN_BIT] && !mem_ready_i) begin
                    stall_c_o                    = 1'b1;
                    cw_c_o[RF_W_BIT]             = 1'b0;
                    cw_c_o[STATUS_LD_BIT]        = 1'b0;
                    cw_c_o[PC_FS_LSB +: PC_FS_W] = PC_FS_HOLD;
                end
            end
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches into the instruction register, then
// steps through decoder micro-states, holding status flags and a fetch watchdog.
module control_sequencer
    import cu_pkg::*;
#(
    parameter int unsigned FETCH_WAIT_MAX = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [K_W-1:0]      databus,
    input  logic                mem_ready,
    input  logic [CW_WIDTH-1:0] cw_in,
    input  logic [K_W-1:0]      k_in,
    input  logic [STATUS_W-1:0] alu_status,
    output logic [INSTR_W-1:0]  instruction,
    output logic [NS_W-1:0]     state,
    output logic [STATUS_W-1:0] status,
    output logic [CW_WIDTH-1:0] cw_out,
    output logic [K_W-1:0]      k_out,
    output logic                fetching,
    output logic                fetch_timeout
);

    localparam int unsigned WAIT_W = (FETCH_WAIT_MAX < 1) ? 1 : $clog2(FETCH_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(FETCH_WAIT_MAX);

    phase_e              phase_q,   phase_d;
    logic [INSTR_W-1:0]  instr_q,   instr_d;
    logic [NS_W-1:0]     state_q,   state_d;
    logic [STATUS_W-1:0] status_q,  status_d;
    logic [WAIT_W-1:0]   wait_q,    wait_d;
    logic                timeout_q, timeout_d;
    logic                stall_c;
    logic [CW_WIDTH-1:0] cw_c;
    logic                unused_databus;

    assign unused_databus = ^databus[K_W-1:INSTR_W];

    cw_gate u_cw_gate (
        .reset_n_i   (reset_n),
        .phase_i     (phase_q),
        .mem_ready_i (mem_ready),
        .cw_i        (cw_in),
        .cw_c_o      (cw_c),
        .stall_c_o   (stall_c)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            phase_q   <= FETCH;
            instr_q   <= '0;
            state_q   <= '0;
            status_q  <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            instr_q   <= instr_d;
            state_q   <= state_d;
            status_q  <= status_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        instr_d   = instr_q;
        state_d   = state_q;
        status_d  = status_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (phase_q)
            FETCH: begin
                if (mem_ready) begin
                    instr_d = databus[INSTR_W-1:0];
                    state_d = '0;
                    wait_d  = '0;
                    phase_d = EXEC;
                end else begin
                    // Counter saturates; the flag is sticky until reset.
                    if (wait_q != WAIT_LIMIT) begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                    if (wait_d == WAIT_LIMIT) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (!stall_c) begin
                    if (cw_c[STATUS_LD_BIT]) begin
                        status_d = alu_status;
                    end
                    if (cw_c[NEXT_STATE_LSB +: NS_W] == '0) begin
                        phase_d = FETCH;
                    end else begin
                        state_d = cw_c[NEXT_STATE_LSB +: NS_W];
                    end
                end
            end
            default: phase_d = FETCH;
        endcase
    end

    assign cw_out        = cw_c;
    assign k_out         = (reset_n && phase_q == EXEC) ? k_in : '0;
    assign fetching      = reset_n && (phase_q == FETCH);
    assign instruction   = instr_q;
    assign state         = state_q;
    assign status        = status_q;
    assign fetch_timeout = timeout_q;

endmodule
